// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, memory handshakes, retire counter.
// Define ILLEGAL_TRAP_EN to add the TRAP state with illegal_o / trap_ack_i; otherwise unknown opcodes retire as NOPs.
module multicycle_control #(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 0,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [6:0]          opcode_i,
  input  logic                if_ready_i,
  input  logic                dm_ready_i,
`ifdef ILLEGAL_TRAP_EN
  input  logic                trap_ack_i,
  output logic                illegal_o,
`endif
  output logic                if_req_o,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic                reg_write_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                alu_src_o,
  output logic                alu_data1_o,
  output logic                mem_write_o,
  output logic                mem_read_o,
  output logic                mem_to_reg_o,
  output logic                branch_o,
  output logic                jump_o,
  output logic                bus_err_o,
  output logic [RETIRE_W-1:0] retired_o
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] TO_LAST = WC_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  function automatic logic op_known(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [6:0]          opc_q, opc_d;
  logic [WC_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                bus_err_q, bus_err_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                if_req_q, if_req_d;
  logic                pc_write_q, pc_write_d;
  logic                reg_write_q, reg_write_d;
  logic [2:0]          alu_op_q, alu_op_d;
  logic                alu_src_q, alu_src_d;
  logic                alu_data1_q, alu_data1_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_to_reg_q, mem_to_reg_d;
  logic                branch_q, branch_d;
  logic                jump_q, jump_d;
  logic                illegal_q, illegal_d;

  logic timeout_hit, waiting, fetch_abort, retire, trap_done;

  // Handshake-qualified strobes follow the ready input in the same cycle; everything else is a flop.
  assign retire = pc_write_q | (mem_write_q & dm_ready_i);
`ifdef ILLEGAL_TRAP_EN
  assign trap_done = illegal_q & trap_ack_i;
  assign illegal_o = illegal_q;
`else
  assign trap_done = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    bus_err_d   = bus_err_q;
    waiting     = 1'b0;
    fetch_abort = 1'b0;
    timeout_hit = (MEM_TIMEOUT > 0) && (wait_cnt_q == TO_LAST);

    case (state_q)
      S_FETCH: begin
        // The first FETCH cycle after reset or an abandoned fetch only launches the request.
        if (if_req_q) begin
          if (if_ready_i) begin
            state_d = S_DECODE;
          end else if (timeout_hit) begin
            bus_err_d   = 1'b1;
            fetch_abort = 1'b1;
          end else begin
            waiting = 1'b1;
          end
        end
      end
      S_DECODE: begin
        opc_d = opcode_i;
        if (op_known(opcode_i)) begin
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_WB;
`endif
        end
      end
      S_EXEC: begin
        if (opc_q == OP_BR) begin
          state_d = S_FETCH;
        end else if (opc_q == OP_LOAD || opc_q == OP_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dm_ready_i) begin
          state_d = (opc_q == OP_STORE) ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB: state_d = S_FETCH;
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        if (trap_ack_i) state_d = S_FETCH;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase

    wait_cnt_d = waiting ? wait_cnt_q + WC_W'(1) : '0;
    retired_d  = retired_q + RETIRE_W'(retire);

    // Registered controls describe the state being entered, so they are valid for its whole cycle.
    if_req_d     = (state_d == S_FETCH) && !fetch_abort;
    pc_write_d   = (state_d == S_WB) || (state_d == S_EXEC && opc_d == OP_BR);
    reg_write_d  = (state_d == S_WB) && op_known(opc_d);
    mem_to_reg_d = (state_d == S_WB) && (opc_d == OP_LOAD);
    jump_d       = (state_d == S_WB) && (opc_d == OP_JAL || opc_d == OP_JALR);
    mem_read_d   = (state_d == S_MEM) && (opc_d == OP_LOAD);
    mem_write_d  = (state_d == S_MEM) && (opc_d == OP_STORE);
    branch_d     = (state_d == S_EXEC) && (opc_d == OP_BR);
    illegal_d    = (state_d == S_TRAP);

    alu_op_d    = 3'b000;
    alu_src_d   = 1'b0;
    alu_data1_d = 1'b0;
    if (state_d == S_EXEC) begin
      case (opc_d)
        OP_R:                        alu_op_d = 3'b010;
        OP_I:              begin alu_op_d = 3'b011; alu_src_d = 1'b1; end
        OP_BR:                       alu_op_d = 3'b001;
        OP_LUI:            begin alu_op_d = 3'b100; alu_src_d = 1'b1; end
        OP_AUIPC, OP_JAL:  begin alu_src_d = 1'b1; alu_data1_d = 1'b1; end
        OP_LOAD, OP_STORE, OP_JALR:  alu_src_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_FETCH;
      opc_q        <= '0;
      wait_cnt_q   <= '0;
      bus_err_q    <= 1'b0;
      retired_q    <= '0;
      if_req_q     <= 1'b0;
      pc_write_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_op_q     <= '0;
      alu_src_q    <= 1'b0;
      alu_data1_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
      jump_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      opc_q        <= opc_d;
      wait_cnt_q   <= wait_cnt_d;
      bus_err_q    <= bus_err_d;
      retired_q    <= retired_d;
      if_req_q     <= if_req_d;
      pc_write_q   <= pc_write_d;
      reg_write_q  <= reg_write_d;
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      alu_data1_q  <= alu_data1_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      mem_to_reg_q <= mem_to_reg_d;
      branch_q     <= branch_d;
      jump_q       <= jump_d;
      illegal_q    <= illegal_d;
    end
  end

  assign if_req_o     = if_req_q;
  assign ir_write_o   = if_req_q & if_ready_i;
  assign pc_write_o   = retire | trap_done;
  assign reg_write_o  = reg_write_q;
  assign alu_op_o     = ALU_OP_W'(alu_op_q);
  assign alu_src_o    = alu_src_q;
  assign alu_data1_o  = alu_data1_q;
  assign mem_write_o  = mem_write_q;
  assign mem_read_o   = mem_read_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign branch_o     = branch_q;
  assign jump_o       = jump_q;
  assign bus_err_o    = bus_err_q;
  assign retired_o    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of instruction latencies, hand-written timeout/reset cases and
// random instruction streams, all checked cycle by cycle against an instruction-level model.
module tb_multicycle_control;
  localparam int TO = 4;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] opcode;
  logic if_ready, dm_ready, trap_ack;
  logic if_req, ir_write, pc_write, reg_write;
  logic [2:0] alu_op;
  logic alu_src, alu_data1, mem_write, mem_read, mem_to_reg, branch, jump, bus_err;
  logic [RW-1:0] retired;
  logic illegal_obs;

  typedef struct packed {
    logic       if_req, ir_write, pc_write, reg_write;
    logic [2:0] alu_op;
    logic       alu_src, alu_data1, mem_write, mem_read, mem_to_reg, branch, jump;
  } ctl_t;

  ctl_t obs;
  assign obs = {if_req, ir_write, pc_write, reg_write, alu_op, alu_src, alu_data1,
                mem_write, mem_read, mem_to_reg, branch, jump};

  always #5 clk = ~clk;

  multicycle_control #(.ALU_OP_W(3), .MEM_TIMEOUT(TO), .RETIRE_W(RW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .opcode_i(opcode), .if_ready_i(if_ready), .dm_ready_i(dm_ready),
`ifdef ILLEGAL_TRAP_EN
    .trap_ack_i(trap_ack), .illegal_o(illegal_obs),
`endif
    .if_req_o(if_req), .ir_write_o(ir_write), .pc_write_o(pc_write), .reg_write_o(reg_write),
    .alu_op_o(alu_op), .alu_src_o(alu_src), .alu_data1_o(alu_data1), .mem_write_o(mem_write),
    .mem_read_o(mem_read), .mem_to_reg_o(mem_to_reg), .branch_o(branch), .jump_o(jump),
    .bus_err_o(bus_err), .retired_o(retired)
  );
`ifndef ILLEGAL_TRAP_EN
  assign illegal_obs = 1'b0;
`endif

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, L = 7'b0000011, S = 7'b0100011;
  localparam logic [6:0] B = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, BAD = 7'b1111111;

  int checks = 0, errors = 0;
  int m_ret = 0;
  bit m_err = 0, m_launch = 1;
  int cyc, first_pc;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit known(input logic [6:0] op);
    return op inside {R, I, L, S, B, JAL, JALR, LUI, AUIPC};
  endfunction

  // Expected EXEC-cycle controls straight from the instruction-class table.
  function automatic ctl_t exec_ctl(input logic [6:0] op);
    ctl_t e = '0;
    case (op)
      R:            e.alu_op = 3'b010;
      I:            begin e.alu_op = 3'b011; e.alu_src = 1'b1; end
      L, S, JALR:   e.alu_src = 1'b1;
      AUIPC, JAL:   begin e.alu_src = 1'b1; e.alu_data1 = 1'b1; end
      LUI:          begin e.alu_op = 3'b100; e.alu_src = 1'b1; end
      B:            begin e.alu_op = 3'b001; e.branch = 1'b1; e.pc_write = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic void check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endfunction

  // One clock cycle: drive inputs, compare at the falling edge, then advance the model.
  task automatic step(input ctl_t e, input logic ifr, input logic dmr, input logic ack,
                      input logic ill, input bit ret, input bit set_err, input string tag);
    if_ready = ifr;
    dm_ready = dmr;
    trap_ack = ack;
    @(negedge clk);
    cyc++;
    if (obs.pc_write && first_pc == 0) first_pc = cyc;
    checks++;
    if ({obs, bus_err, retired, illegal_obs} !== {e, m_err, RW'(m_ret), ill}) begin
      errors++;
      $display("FAIL %s cyc%0d: got ctl=%b err=%b ret=%0d ill=%b, want ctl=%b err=%b ret=%0d ill=%b",
               tag, cyc, obs, bus_err, retired, illegal_obs, e, m_err, m_ret, ill);
    end
    @(posedge clk);
    #1;
    if (ret) m_ret = (m_ret + 1) % (1 << RW);
    if (set_err) m_err = 1'b1;
  endtask

  // Runs one instruction; lat is the DUT cycle (from first fetch cycle) where pc_write_o was seen, 0 if never.
  task automatic run_instr(input logic [6:0] op, input int fwait, input int mwait, input int twait,
                           output int lat);
    ctl_t e;
    int w, cnt;
    bit is_l, is_s;
    is_l = (op == L);
    is_s = (op == S);
    opcode = 7'($urandom);
    if (m_launch) begin
      step('0, 1'b0, rb(), 1'b0, 1'b0, 0, 0, "launch");
      m_launch = 0;
    end
    cyc = 0;
    first_pc = 0;
    w = fwait;
    cnt = 0;
    while (w > 0) begin
      e = '0;
      e.if_req = 1'b1;
      if (cnt == TO - 1) begin
        step(e, 1'b0, rb(), 1'b0, 1'b0, 0, 1, "fetch_timeout");
        step('0, 1'b0, rb(), 1'b0, 1'b0, 0, 0, "relaunch");
        cnt = 0;
      end else begin
        step(e, 1'b0, rb(), 1'b0, 1'b0, 0, 0, "fetch_wait");
        cnt++;
      end
      w--;
    end
    e = '0;
    e.if_req = 1'b1;
    e.ir_write = 1'b1;
    step(e, 1'b1, rb(), 1'b0, 1'b0, 0, 0, "fetch");
    opcode = op;
    step('0, rb(), rb(), 1'b0, 1'b0, 0, 0, "decode");
    opcode = 7'($urandom);
    if (!known(op)) begin
      e = '0;
      e.pc_write = 1'b1;
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < twait; i++) step('0, rb(), rb(), 1'b0, 1'b1, 0, 0, "trap_hold");
      step(e, rb(), rb(), 1'b1, 1'b1, 0, 0, "trap_ack");
`else
      if (twait < 0) $display("note: negative trap wait");
      step(e, rb(), rb(), 1'b0, 1'b0, 1, 0, "nop_wb");
`endif
      lat = first_pc;
      return;
    end
    step(exec_ctl(op), rb(), rb(), 1'b0, 1'b0, op == B, 0, "exec");
    if (op == B) begin
      lat = first_pc;
      return;
    end
    if (is_l || is_s) begin
      w = mwait;
      cnt = 0;
      while (1) begin
        e = '0;
        e.mem_read = is_l;
        e.mem_write = is_s;
        if (w == 0) begin
          e.pc_write = is_s;
          step(e, rb(), 1'b1, 1'b0, 1'b0, is_s, 0, "mem_done");
          break;
        end else if (cnt == TO - 1) begin
          step(e, rb(), 1'b0, 1'b0, 1'b0, 0, 1, "mem_timeout");
          lat = first_pc;
          return;
        end else begin
          step(e, rb(), 1'b0, 1'b0, 1'b0, 0, 0, "mem_wait");
          cnt++;
          w--;
        end
      end
      if (is_s) begin
        lat = first_pc;
        return;
      end
    end
    e = '0;
    e.reg_write = 1'b1;
    e.pc_write = 1'b1;
    e.mem_to_reg = is_l;
    e.jump = (op == JAL) || (op == JALR);
    step(e, rb(), rb(), 1'b0, 1'b0, 1, 0, "wb");
    lat = first_pc;
  endtask

  typedef struct {
    string      name;
    logic [6:0] op;
    int         fw;
    int         mw;
    int         lat;
  } vec_t;

  vec_t tbl[13];
  logic [6:0] rops[12];
  int lat;

  initial begin
    tbl[0]  = '{"R",            R,     0, 0, 4};
    tbl[1]  = '{"I fwait1",     I,     1, 0, 5};
    tbl[2]  = '{"LOAD",         L,     0, 0, 5};
    tbl[3]  = '{"LOAD mwait3",  L,     0, 3, 8};
    tbl[4]  = '{"STORE",        S,     0, 0, 4};
    tbl[5]  = '{"STORE mwait2", S,     0, 2, 6};
    tbl[6]  = '{"BRANCH",       B,     0, 0, 3};
    tbl[7]  = '{"JAL",          JAL,   0, 0, 4};
    tbl[8]  = '{"JALR fwait2",  JALR,  2, 0, 6};
    tbl[9]  = '{"LUI",          LUI,   0, 0, 4};
    tbl[10] = '{"AUIPC",        AUIPC, 0, 0, 4};
    tbl[11] = '{"ILLEGAL",      BAD,   0, 0, 3};
    tbl[12] = '{"R fwait3",     R,     3, 0, 7};
    rops = '{R, I, L, S, B, JAL, JALR, LUI, AUIPC, BAD, 7'b0001111, 7'b0000000};

    rst_n = 1'b0;
    opcode = '0;
    if_ready = 1'b0;
    dm_ready = 1'b0;
    trap_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", int'(obs), 0);
    check("reset_retired", int'(retired), 0);
    check("reset_bus_err", int'(bus_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].fw, tbl[i].mw, 0, lat);
      check({"latency ", tbl[i].name}, lat, tbl[i].lat);
    end

    // Store whose data memory never answers: abandoned after TO cycles, no retire, sticky error.
    run_instr(S, 0, TO, 0, lat);
    check("store_timeout_no_retire", lat, 0);
    run_instr(R, 0, 0, 0, lat);
    check("latency after mem timeout", lat, 4);
    check("bus_err_sticky", int'(bus_err), 1);

    // Fetch that times out once and is relaunched.
    run_instr(R, TO + 1, 0, 0, lat);
    check("latency fetch timeout", lat, 10);

    // Reset asserted in the middle of a store's MEM phase.
    step('{if_req: 1'b1, ir_write: 1'b1, default: '0}, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "rs_fetch");
    opcode = S;
    step('0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "rs_decode");
    step(exec_ctl(S), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "rs_exec");
    step('{mem_write: 1'b1, default: '0}, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "rs_mem");
    #2;
    check("mem_write_before_reset", int'(mem_write), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_ctl", int'(obs), 0);
    check("async_reset_retired", int'(retired), 0);
    check("async_reset_bus_err", int'(bus_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ret = 0;
    m_err = 0;
    m_launch = 1;
    run_instr(R, 0, 0, 0, lat);
    check("latency after reset", lat, 4);
    check("retired after reset", int'(retired), 1);

    for (int n = 0; n < 80; n++) begin
      run_instr(rops[$urandom_range(0, 11)], $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 2), lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
